ex_div: RTL and testbench



---
 rtl/ex_div.sv | 158 +++++++++++++++
 tb/tb_ex_div.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_div.sv
// ex_div: iterative 32-bit radix-2 restoring divider for the EX stage.
// It holds stallreq_for_ex high while a DIV/DIVU is in progress. It then
// presents the quotient (LO) and remainder (HI) for exactly one cycle, with
// div_ready high.
// Optional build macro: DIV_ZERO_FAST_EN. When it is defined, a zero divisor
// skips the 32-step iteration and the divider goes straight to DONE.
module ex_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_start,
    input  logic        div_signed,
    input  logic [31:0] opdata1,
    input  logic [31:0] opdata2,
    output logic        stallreq_for_ex,
    output logic        div_ready,
    output logic [31:0] div_quot,
    output logic [31:0] div_rem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [5:0]  cnt;
    logic [31:0] quot_q;
    logic [31:0] rem_q;
    logic [31:0] dvsr_q;
    logic [31:0] op1_q;
    logic        neg_q;
    logic        rsign_q;
    logic        zero_q;

    logic        sign1;
    logic        sign2;
    logic [31:0] mag1;
    logic [31:0] mag2;

    logic [32:0] shifted;
    logic [33:0] trial;
    logic [31:0] step_quot;
    logic [31:0] step_rem;
    logic        last_step;
    logic [31:0] fix_quot;
    logic [31:0] fix_rem;

    // Operand magnitudes and signs, used when a new divide is accepted in IDLE
    always_comb begin
        sign1 = div_signed & opdata1[31];
        sign2 = div_signed & opdata2[31];
        mag1  = sign1 ? (~opdata1 + 32'd1) : opdata1;
        mag2  = sign2 ? (~opdata2 + 32'd1) : opdata2;
    end

    // One restoring step, plus the sign/zero fix-up of the final step's result
    always_comb begin
        shifted   = {rem_q, quot_q[31]};
        trial     = {1'b0, shifted} - {2'b00, dvsr_q};
        step_quot = {quot_q[30:0], 1'b0};
        step_rem  = shifted[31:0];
        if (!trial[33]) begin
            step_quot[0] = 1'b1;
            step_rem     = trial[31:0];
        end
        last_step = (cnt == 6'd31);
        if (zero_q) begin
            fix_quot = '1;
            fix_rem  = op1_q;
        end else begin
            fix_quot = neg_q   ? (~step_quot + 32'd1) : step_quot;
            fix_rem  = rsign_q ? (~step_rem  + 32'd1) : step_rem;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic; DONE always returns to IDLE, so a new start is never taken in DONE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (div_start) begin
`ifdef DIV_ZERO_FAST_EN
                    if (opdata2 == '0) state_nxt = DONE;
                    else               state_nxt = BUSY;
`else
                    state_nxt = BUSY;
`endif
                end
            end
            BUSY:    if (last_step) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: latch operands in IDLE, iterate in BUSY, register results on the last step
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            dvsr_q   <= '0;
            op1_q    <= '0;
            neg_q    <= 1'b0;
            rsign_q  <= 1'b0;
            zero_q   <= 1'b0;
            div_quot <= '0;
            div_rem  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (div_start) begin
                        cnt     <= '0;
                        quot_q  <= mag1;
                        rem_q   <= '0;
                        dvsr_q  <= mag2;
                        op1_q   <= opdata1;
                        neg_q   <= sign1 ^ sign2;
                        rsign_q <= sign1;
                        zero_q  <= (opdata2 == '0);
`ifdef DIV_ZERO_FAST_EN
                        if (opdata2 == '0) begin
                            div_quot <= '1;
                            div_rem  <= opdata1;
                        end
`endif
                    end
                end
                BUSY: begin
                    quot_q <= step_quot;
                    rem_q  <= step_rem;
                    cnt    <= cnt + 6'd1;
                    if (last_step) begin
                        div_quot <= fix_quot;
                        div_rem  <= fix_rem;
                    end
                end
                default: ;
            endcase
        end
    end

    // The stall request is forced low while reset is asserted, even if a divide is waiting in EX
    always_comb begin
        stallreq_for_ex = rst & (((state == IDLE) & div_start) | (state == BUSY));
        div_ready       = (state == DONE);
    end

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: self-checking bench for ex_div with a behavioural reference model.
module tb_ex_div;

    logic        clk;
    logic        rst;
    logic        div_start;
    logic        div_signed;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        stallreq_for_ex;
    logic        div_ready;
    logic [31:0] div_quot;
    logic [31:0] div_rem;

    int checks   = 0;
    int failures = 0;

    ex_div dut (
        .clk             (clk),
        .rst             (rst),
        .div_start       (div_start),
        .div_signed      (div_signed),
        .opdata1         (opdata1),
        .opdata2         (opdata2),
        .stallreq_for_ex (stallreq_for_ex),
        .div_ready       (div_ready),
        .div_quot        (div_quot),
        .div_rem         (div_rem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: divide with plain integer arithmetic (truncating toward zero)
    function automatic void ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sa, sb, lq, lr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic int exp_stall(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
        if (b == 32'd0) return 1;
`endif
        return 33;
    endfunction

    // Runs one divide; call at posedge+1. Returns at posedge+1 of the DONE cycle when hold=1,
    // otherwise one cycle later with div_start dropped.
    task automatic do_div(input string name, input bit sgn, input logic [31:0] a,
                          input logic [31:0] b, input bit hold);
        logic [31:0] eq, er;
        int stalls;
        bit timeout;
        ref_div(sgn, a, b, eq, er);
        div_start  = 1'b1;
        div_signed = sgn;
        opdata1    = a;
        opdata2    = b;
        #1;
        checks++;
        if (stallreq_for_ex !== 1'b1) begin
            failures++;
            $display("FAIL %s stall_first_cycle got=%b exp=1", name, stallreq_for_ex);
        end
        stalls  = 1;
        timeout = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (stallreq_for_ex !== 1'b1) break;
            stalls++;
            if (stalls > 40) begin
                timeout = 1'b1;
                break;
            end
        end
        checks++;
        if (timeout) begin
            failures++;
            $display("FAIL %s stall_timeout got=>40 exp=%0d", name, exp_stall(b));
        end else if (stalls != exp_stall(b)) begin
            failures++;
            $display("FAIL %s stall_cycles got=%0d exp=%0d", name, stalls, exp_stall(b));
        end
        checks++;
        if (div_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s ready got=%b exp=1", name, div_ready);
        end
        checks++;
        if (div_quot !== eq || div_rem !== er) begin
            failures++;
            $display("FAIL %s result a=%h b=%h s=%0d got q=%h r=%h exp q=%h r=%h",
                     name, a, b, sgn, div_quot, div_rem, eq, er);
        end
        if (!hold) begin
            div_start = 1'b0;
            @(posedge clk); #1;
            checks++;
            if (div_ready !== 1'b0 || stallreq_for_ex !== 1'b0 || div_quot !== eq || div_rem !== er) begin
                failures++;
                $display("FAIL %s after_done ready=%b stall=%b q=%h r=%h exp ready=0 stall=0 q=%h r=%h",
                         name, div_ready, stallreq_for_ex, div_quot, div_rem, eq, er);
            end
        end
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        div_start  = 1'b1;
        div_signed = 1'b0;
        opdata1    = 32'd100;
        opdata2    = 32'd7;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (stallreq_for_ex !== 1'b0 || div_ready !== 1'b0 || div_quot !== 32'd0 || div_rem !== 32'd0) begin
            failures++;
            $display("FAIL reset_state stall=%b ready=%b q=%h r=%h exp 0 0 0 0",
                     stallreq_for_ex, div_ready, div_quot, div_rem);
        end
        div_start = 1'b0;
        rst       = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        do_div("divu_100_7",    1'b0, 32'd100,        32'd7,          1'b0);
        do_div("div_m7_2",      1'b1, 32'hFFFF_FFF9,  32'd2,          1'b0);
        do_div("div_7_m2",      1'b1, 32'd7,          32'hFFFF_FFFE,  1'b0);
        do_div("div_min_m1",    1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  1'b0);
        do_div("divu_min_m1",   1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  1'b0);
        do_div("divu_5_0",      1'b0, 32'd5,          32'd0,          1'b0);
        do_div("div_m5_0",      1'b1, 32'hFFFF_FFFB,  32'd0,          1'b0);
        do_div("divu_max_1",    1'b0, 32'hFFFF_FFFF,  32'd1,          1'b0);
        do_div("divu_3_max",    1'b0, 32'd3,          32'hFFFF_FFFF,  1'b0);
    endtask

    task automatic test_reset_mid_busy();
        div_start  = 1'b1;
        div_signed = 1'b0;
        opdata1    = 32'h1234_5678;
        opdata2    = 32'd13;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (stallreq_for_ex !== 1'b0 || div_ready !== 1'b0 || div_quot !== 32'd0 || div_rem !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid_busy stall=%b ready=%b q=%h r=%h exp 0 0 0 0",
                     stallreq_for_ex, div_ready, div_quot, div_rem);
        end
        div_start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        do_div("divu_9_3_after_rst", 1'b0, 32'd9, 32'd3, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_div("b2b_first", 1'b0, 32'd1000, 32'd33, 1'b1);
        // Operands offered during DONE must not be taken; IDLE samples the next pair.
        opdata1 = 32'd77;
        opdata2 = 32'd4;
        @(posedge clk); #1;
        do_div("b2b_second", 1'b0, 32'hDEAD_BEEF, 32'd1234, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        bit sgn;
        for (int i = 0; i < 24; i++) begin
            a   = $urandom;
            sgn = $urandom_range(0, 1);
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = ~($urandom_range(0, 15));
                default: b = $urandom;
            endcase
            do_div("random", sgn, a, b, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid_busy();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
